// File: rtl/asi_pkg.sv
// Shared definitions for the ASI read/write user-memory arbiter.
//   owner_e         : who currently owns the user memory port (IDLE/RD/WR)
//   ARB_WR_FIRST    : ASI_ARB encoding, write side wins a simultaneous request
//   ARB_RD_FIRST    : ASI_ARB encoding, read side wins a simultaneous request
//   pick_owner()    : tie-break selection used from IDLE and at burst end
package asi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } owner_e;

    localparam int ARB_WR_FIRST = 0;
    localparam int ARB_RD_FIRST = 1;

    localparam int BURST_CNT_W = 8;

    // Plain priority pick between the two requesters, no fairness applied.
    function automatic owner_e pick_owner(input logic rreq,
                                          input logic wreq,
                                          input logic rd_first);
        if (rreq && wreq) return rd_first ? RD : WR;
        if (rreq)         return RD;
        if (wreq)         return WR;
        return IDLE;
    endfunction

endpackage

// File: rtl/asi_rw_arb.sv
// Arbiter granting the single user memory port to either the read or the
// write interface, one burst at a time, with a fairness limit on consecutive
// bursts and a sticky no-progress watchdog.
//
// Ports
//   usr_clk, usr_reset_n        : clock, asynchronous active-low reset
//   usr_rrequest/usr_re/usr_rlast : read side request, beat strobe, last beat
//   usr_rgrant                  : read side owns the port (registered)
//   usr_wrequest/usr_we/usr_wlast : write side request, beat strobe, last beat
//   usr_wgrant                  : write side owns the port (registered)
//   arb_stall                   : sticky watchdog flag
//   arb_stall_clr               : clears arb_stall (a simultaneous set wins)
module asi_rw_arb
    import asi_pkg::*;
#(
    parameter int ASI_ARB  = ARB_WR_FIRST,  // 1 = read wins ties, 0 = write wins
    parameter int ARB_MAXB = 4,             // 1..255 consecutive bursts per side
    parameter int ARB_WDOG = 1024           // idle owned cycles before stall, 0 = off
) (
    input  logic usr_clk,
    input  logic usr_reset_n,
    input  logic usr_rrequest,
    input  logic usr_re,
    input  logic usr_rlast,
    output logic usr_rgrant,
    input  logic usr_wrequest,
    input  logic usr_we,
    input  logic usr_wlast,
    output logic usr_wgrant,
    output logic arb_stall,
    input  logic arb_stall_clr
);

    localparam int WDOG_W = (ARB_WDOG > 1) ? $clog2(ARB_WDOG + 1) : 1;
    localparam logic [WDOG_W-1:0]      WDOG_MAX = WDOG_W'(ARB_WDOG);
    localparam logic [BURST_CNT_W-1:0] MAXB_C   = BURST_CNT_W'(ARB_MAXB);
    localparam logic                   RD_FIRST = (ASI_ARB == ARB_RD_FIRST);

    owner_e                  state_q, state_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                    started_q, started_d;
    logic [WDOG_W-1:0]       wdog_cnt_q, wdog_cnt_d;
    logic                    stall_q, stall_d;

    logic                    own_req, own_beat, own_last, other_req;
    owner_e                  other_side;
    logic [BURST_CNT_W-1:0]  burst_inc;
    logic                    stall_set;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        started_d   = started_q;
        wdog_cnt_d  = wdog_cnt_q;
        stall_set   = 1'b0;
        own_req     = 1'b0;
        own_beat    = 1'b0;
        own_last    = 1'b0;
        other_req   = 1'b0;
        other_side  = IDLE;

        // Only the owner's strobes matter; the non-owner's are ignored.
        case (state_q)
            RD: begin
                own_req    = usr_rrequest;
                own_beat   = usr_re;
                own_last   = usr_re && usr_rlast;
                other_req  = usr_wrequest;
                other_side = WR;
            end
            WR: begin
                own_req    = usr_wrequest;
                own_beat   = usr_we;
                own_last   = usr_we && usr_wlast;
                other_req  = usr_rrequest;
                other_side = RD;
            end
            default: ;
        endcase

        burst_inc = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + 1'b1;

        case (state_q)
            IDLE: state_d = pick_owner(usr_rrequest, usr_wrequest, RD_FIRST);
            RD, WR: begin
                if (own_last) begin
                    // Next owner is chosen in the same cycle so back-to-back
                    // bursts see no idle gap; fairness overrides the tie-break.
                    if (other_req && (burst_inc >= MAXB_C))
                        state_d = other_side;
                    else
                        state_d = pick_owner(usr_rrequest, usr_wrequest, RD_FIRST);
                end else if (!started_q && !own_beat && !own_req) begin
                    // Request withdrawn before any beat: give the port back.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Consecutive-burst count only survives while the same side keeps it.
        if (state_d == IDLE || state_d != state_q)
            burst_cnt_d = '0;
        else if (own_last)
            burst_cnt_d = burst_inc;

        if (state_q == IDLE || own_last)
            started_d = 1'b0;
        else if (own_beat)
            started_d = 1'b1;

        // Watchdog sets the flag only on the step into saturation, so a clear
        // while the owner is still stuck is not immediately undone.
        if (ARB_WDOG == 0 || state_q == IDLE || own_beat) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_MAX) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
            stall_set  = (wdog_cnt_q == WDOG_MAX - WDOG_W'(1));
        end

        stall_d = stall_set || (stall_q && !arb_stall_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values computed before this edge, independent of order.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            started_q   <= 1'b0;
            wdog_cnt_q  <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            started_q   <= started_d;
            wdog_cnt_q  <= wdog_cnt_d;
            stall_q     <= stall_d;
        end
    end

    // Grants decode registered state only, so they are mutually exclusive
    // and have no combinational path from the inputs.
    assign usr_rgrant = (state_q == RD);
    assign usr_wgrant = (state_q == WR);
    assign arb_stall  = stall_q;

endmodule

// File: doc/asi_rw_arb.md
ASI_RW_ARB -- requirements
Module: asi_rw_arb

Interface
REQ-001 SHALL have parameter ASI_ARB, default 0, meaning tie-break priority: 1 = read wins, 0 = write wins.
REQ-002 SHALL have parameter ARB_MAXB, default 4, meaning the maximum consecutive bursts granted to one side while the other side requests (range 1..255).
REQ-003 SHALL have parameter ARB_WDOG, default 1024, meaning the number of owned cycles with no beat before the stall flag sets (0 = watchdog disabled).
REQ-004 SHALL have port usr_clk, input, 1 bit: clock.
REQ-005 SHALL have port usr_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port usr_rrequest, input, 1 bit: read interface has a pending burst.
REQ-007 SHALL have port usr_re, input, 1 bit: read beat issued to user memory.
REQ-008 SHALL have port usr_rlast, input, 1 bit: current read beat is the last of its burst.
REQ-009 SHALL have port usr_rgrant, output, 1 bit: read side owns the user memory port.
REQ-010 SHALL have port usr_wrequest, input, 1 bit: write interface has a pending burst.
REQ-011 SHALL have port usr_we, input, 1 bit: write beat issued.
REQ-012 SHALL have port usr_wlast, input, 1 bit: current write beat is the last of its burst.
REQ-013 SHALL have port usr_wgrant, output, 1 bit: write side owns the port.
REQ-014 SHALL have port arb_stall, output, 1 bit: sticky watchdog flag.
REQ-015 SHALL have port arb_stall_clr, input, 1 bit: clears arb_stall.

Function
REQ-016 SHALL implement states IDLE, RD, WR; usr_rgrant = (state==RD) and usr_wgrant = (state==WR), both decoded from registered state with no combinational path from inputs.
REQ-017 In IDLE: with only rrequest -> RD; with only wrequest -> WR; with both -> the side selected by ASI_ARB; with neither -> stay IDLE.
REQ-018 In RD: usr_re && usr_rlast SHALL end ownership; the next state SHALL be chosen per REQ-017 in the same cycle, with fairness override per REQ-020, so back-to-back owners incur zero idle cycles.
REQ-019 WR SHALL mirror RD using usr_we/usr_wlast/usr_wrequest.
REQ-020 A consecutive-burst counter (8 bits) SHALL increment on each last beat of the owner and reset to 0 on owner change or IDLE; when it reaches ARB_MAXB and the other side requests, the other side SHALL be granted regardless of ASI_ARB.
REQ-021 Per-owner started flag: SHALL set on the first beat (usr_re/usr_we) and clear on the last beat; if the owner's request drops while started==0, the block SHALL return to IDLE next cycle.
REQ-022 Once started==1, grant SHALL be held until the last beat even if the request deasserts.
REQ-023 A single-beat burst (beat and last in the same cycle) SHALL end ownership that cycle.
REQ-024 A beat or last from the non-owner SHALL be ignored (no state change).
REQ-025 The watchdog counter SHALL count owned cycles with no owner beat, reset on any owner beat or on IDLE, and saturate; reaching ARB_WDOG SHALL set arb_stall.
REQ-026 arb_stall_clr SHALL clear arb_stall next cycle; if set and clear occur simultaneously, set wins.
REQ-027 usr_rgrant and usr_wgrant SHALL never be high together.

Reset
REQ-028 Asynchronous assertion of usr_reset_n SHALL force state IDLE, both grants 0, counters 0, started 0, and arb_stall 0; reset mid-burst abandons ownership.
REQ-029 The first grant SHALL be possible in the first cycle after reset deassertion, with the grant visible one cycle later.

Structure
REQ-030 Package asi_pkg SHALL hold the owner state enum (IDLE/RD/WR) and the ASI_ARB encoding constants (ARB_WR_FIRST=0, ARB_RD_FIRST=1).
REQ-031 The block SHALL be a single module with no sub-module; the watchdog and fairness counters are inline.

Verification
REQ-032 Reset release, rrequest=wrequest=1, ASI_ARB=0 -> usr_wgrant=1 at cycle 2, usr_rgrant=0.
REQ-033 Read 4-beat burst with wrequest held, last beat at cycle N -> usr_wgrant=1 at N+1, usr_rgrant=0 at N+1.
REQ-034 ARB_MAXB=2, ASI_ARB=1, both requesting continuously with 1-beat bursts -> grant pattern RD,RD,WR,RD,RD,WR.
REQ-035 Grant RD, then rrequest drops before any usr_re -> IDLE the next cycle, both grants 0.
REQ-036 ARB_WDOG=8, owner RD with no usr_re for 8 cycles -> arb_stall=1 and held; pulse arb_stall_clr -> 0 next cycle.
REQ-037 usr_reset_n asserted mid-write burst -> both grants 0 immediately (asynchronous), state IDLE.
